// File: rtl/modn_updown.sv
// Modulo-M up/down counter with optional prescaler, terminal-count flag, wrap pulse
// and range-checked load. Define MODN_WRAP_CNT_EN to build the saturating 8-bit wrap counter.
module modn_updown #(
    parameter int N = 4,
    parameter int M = 10,
    parameter int P = 1
) (
    input  logic         clk_50,
    input  logic         rst_n,
    input  logic         en,
    input  logic         up,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] cnt_num,
    output logic         tc,
    output logic         wrap,
    output logic         load_err,
    output logic [7:0]   wrap_cnt
);

    localparam int             PSC_W    = (P > 1) ? $clog2(P) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(P - 1);
    localparam logic [PSC_W-1:0] PSC_ONE  = PSC_W'(1);
    localparam logic [N:0]     CNT_LAST = (N+1)'(M - 1);
    localparam logic [N:0]     CNT_MOD  = (N+1)'(M);
    localparam logic [N-1:0]   CNT_ONE  = N'(1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [PSC_W-1:0] psc;
    logic [N:0]       cnt_ext;
    logic [N-1:0]     cnt_nxt;
    logic             tick;
    logic             term;
    logic             load_oor;

    // Comparisons are done one bit wider so M = 2**N cannot alias onto zero.
    assign cnt_ext  = {1'b0, cnt_num};
    assign tick     = en & (psc == PSC_LAST);
    assign term     = up ? (cnt_ext == CNT_LAST) : (cnt_ext == '0);
    assign tc       = tick & term & ~clr & ~load;
    assign load_oor = ({1'b0, load_val} >= CNT_MOD);

    always_comb begin
        cnt_nxt = cnt_num;
        if (up)
            cnt_nxt = term ? '0 : cnt_num + CNT_ONE;
        else
            cnt_nxt = term ? CNT_LAST[N-1:0] : cnt_num - CNT_ONE;
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_num  <= '0;
            psc      <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= tc;
            load_err <= 1'b0;
            if (clr) begin
                cnt_num <= '0;
                psc     <= '0;
            end else if (load) begin
                psc <= '0;
                if (load_oor) begin
                    cnt_num  <= CNT_LAST[N-1:0];
                    load_err <= 1'b1;
                end else begin
                    cnt_num <= load_val;
                end
            end else if (en) begin
                psc <= (psc == PSC_LAST) ? '0 : psc + PSC_ONE;
                if (tick)
                    cnt_num <= cnt_nxt;
            end
        end
    end

`ifdef MODN_WRAP_CNT_EN
    logic [7:0] wrap_cnt_q;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n)
            wrap_cnt_q <= 8'd0;
        else if (clr)
            wrap_cnt_q <= 8'd0;
        else if (tc)
            wrap_cnt_q <= sat_inc8(wrap_cnt_q);
    end

    assign wrap_cnt = wrap_cnt_q;
`else
    assign wrap_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_modn_updown.sv
// Scoreboard bench for modn_updown: M=10/P=1 and M=2**N/P=3 instances driven in parallel.
module tb_modn_updown;

    typedef struct {
        int cnt;
        int psc;
        int wrap;
        int lerr;
        int wcnt;
    } st_t;

    logic       clk_50 = 1'b0;
    logic       rst_n;
    logic       en, up, clr, load;
    logic [3:0] load_val;
    logic [2:0] load_val_b;
    logic [3:0] cnt_a;
    logic [2:0] cnt_b;
    logic       tc_a, tc_b, wrap_a, wrap_b, lerr_a, lerr_b;
    logic [7:0] wcnt_a, wcnt_b;

    int checks = 0;
    int failures = 0;
    st_t sa, sb;
    st_t qa[$];
    st_t qb[$];

    assign load_val_b = load_val[2:0];

    always #10 clk_50 = ~clk_50;

    modn_updown #(.N(4), .M(10), .P(1)) u_a (
        .clk_50(clk_50), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .cnt_num(cnt_a), .tc(tc_a), .wrap(wrap_a),
        .load_err(lerr_a), .wrap_cnt(wcnt_a)
    );

    modn_updown #(.N(3), .M(8), .P(3)) u_b (
        .clk_50(clk_50), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val_b), .cnt_num(cnt_b), .tc(tc_b), .wrap(wrap_b),
        .load_err(lerr_b), .wrap_cnt(wcnt_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic st_t zero_st();
        st_t z;
        z.cnt = 0; z.psc = 0; z.wrap = 0; z.lerr = 0; z.wcnt = 0;
        return z;
    endfunction

    function automatic st_t model(input st_t s, input int m, input int p, input bit e,
                                  input bit u, input bit c, input bit l, input int lv,
                                  output bit tc_o);
        st_t n;
        bit  tick, term;
        n     = s;
        tick  = e && (s.psc == p - 1);
        term  = u ? (s.cnt == m - 1) : (s.cnt == 0);
        tc_o  = tick && term && !c && !l;
        n.wrap = tc_o ? 1 : 0;
        n.lerr = 0;
        if (c) begin
            n.cnt = 0; n.psc = 0; n.wcnt = 0;
        end else if (l) begin
            n.psc = 0;
            if (lv < m) n.cnt = lv;
            else begin n.cnt = m - 1; n.lerr = 1; end
        end else if (e) begin
            n.psc = (s.psc == p - 1) ? 0 : s.psc + 1;
            if (tick) begin
                if (u) n.cnt = term ? 0 : s.cnt + 1;
                else   n.cnt = term ? m - 1 : s.cnt - 1;
            end
        end
`ifdef MODN_WRAP_CNT_EN
        if (!c && tc_o && s.wcnt < 255) n.wcnt = s.wcnt + 1;
`else
        n.wcnt = 0;
`endif
        return n;
    endfunction

    task automatic cmp_outputs();
        check("a_cnt", int'(cnt_a), sa.cnt);
        check("a_wrap", int'(wrap_a), sa.wrap);
        check("a_load_err", int'(lerr_a), sa.lerr);
        check("a_wrap_cnt", int'(wcnt_a), sa.wcnt);
        check("b_cnt", int'(cnt_b), sb.cnt);
        check("b_wrap", int'(wrap_b), sb.wrap);
        check("b_load_err", int'(lerr_b), sb.lerr);
        check("b_wrap_cnt", int'(wcnt_b), sb.wcnt);
    endtask

    // Drive one cycle: check tc before the edge, queue next state, compare after the edge.
    task automatic step(input bit e, input bit u, input bit c, input bit l, input int v);
        bit ta, tb;
        en = e; up = u; clr = c; load = l; load_val = 4'(v);
        #1;
        qa.push_back(model(sa, 10, 1, e, u, c, l, v, ta));
        qb.push_back(model(sb, 8, 3, e, u, c, l, v % 8, tb));
        check("a_tc", int'(tc_a), int'(ta));
        check("b_tc", int'(tc_b), int'(tb));
        @(posedge clk_50);
        #1;
        if (qa.size() == 0 || qb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            sa = qa.pop_front();
            sb = qb.pop_front();
            cmp_outputs();
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 0; up = 0; clr = 0; load = 0; load_val = 0;
        sa = zero_st(); sb = zero_st();
        #15;
        cmp_outputs();
        repeat (2) @(posedge clk_50);
        @(negedge clk_50);
        rst_n = 1'b1;

        // Up count through wrap from reset.
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0);

        // Down count from 2 through zero.
        step(0, 0, 0, 1, 2);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);

        // Prescaled run with an enable gap.
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);

        // Priority and load range.
        step(1, 1, 1, 1, 5);
        step(0, 1, 0, 1, 12);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 9);
        step(1, 1, 0, 1, 3);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 1, 15);

        // Random traffic including direction changes.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
                 int'($urandom_range(0, 15)));

        // Asynchronous reset between edges at count 7.
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 1, 7);
        #4;
        rst_n = 1'b0;
        #1;
        sa = zero_st(); sb = zero_st();
        cmp_outputs();
        #2;
        rst_n = 1'b1;
        step(1, 1, 0, 0, 0);

        // Many wraps to drive the wrap counter into saturation, then clear it.
        for (int i = 0; i < 3010; i++) step(1, 1, 0, 0, 0);
        check("a_wrap_cnt_final", int'(wcnt_a),
`ifdef MODN_WRAP_CNT_EN
              255
`else
              0
`endif
        );
        step(0, 1, 1, 0, 0);
        check("a_wrap_cnt_cleared", int'(wcnt_a), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=0 expected=1");
        $fatal(1, "timeout");
    end

endmodule
